s_des_round_engine: RTL and testbench

S_DES_ROUND_ENGINE -- requirements
Module: s_des_round_engine

---
 rtl/s_des_round_engine.sv | 182 ++++++++++++++++++
 tb/tb_s_des_round_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_des_round_engine.sv
// Iterative S-DES engine: one Feistel round per clock, valid/ready handshake on input and output.
// Define S_DES_IP_EN to apply IP on capture and IP^-1 on output (identity otherwise).
module s_des_round_engine #(
    parameter int NUM_ROUNDS      = 2,
    parameter int KEY_SHIFT_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic [9:0]  in_key,
    input  logic        in_decrypt,
    input  logic [31:0] S0,
    input  logic [31:0] S1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam int         SHIFT0     = KEY_SHIFT_FIRST % 5;

    state_t      state_r;
    state_t      state_n;
    logic [3:0]  cnt_r;
    logic [7:0]  data_r;
    logic [9:0]  key_r;
    logic        dec_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [7:0]  out_data_r;
    logic [3:0]  round_idx_s;
    logic [7:0]  subkey_s;
    logic [7:0]  fk_s;

    function automatic logic [7:0] ip_fwd(input logic [7:0] d);
`ifdef S_DES_IP_EN
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
`else
        return d;
`endif
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
`ifdef S_DES_IP_EN
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
`else
        return d;
`endif
    endfunction

    function automatic logic [4:0] rol5(input logic [4:0] x, input logic [2:0] n);
        logic [4:0] y;
        case (n)
            3'd0:    y = x;
            3'd1:    y = {x[3:0], x[4]};
            3'd2:    y = {x[2:0], x[4:3]};
            3'd3:    y = {x[1:0], x[4:2]};
            3'd4:    y = {x[0], x[4:1]};
            default: y = x;
        endcase
        return y;
    endfunction

    // Cumulative rotate for a round: first shift, plus 2 per later round, wrapped mod 5.
    function automatic logic [2:0] rot_amt(input logic [3:0] idx);
        int t;
        t = (SHIFT0 + 2 * int'(idx)) % 5;
        return 3'(t);
    endfunction

    function automatic logic [7:0] subkey(input logic [9:0] k, input logic [3:0] idx);
        logic [9:0] p;
        logic [9:0] b;
        p = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
        b = {rol5(p[9:5], rot_amt(idx)), rol5(p[4:0], rot_amt(idx))};
        return {b[4], b[7], b[3], b[6], b[2], b[5], b[0], b[1]};
    endfunction

    function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] x);
        logic [3:0]  e;
        logic [31:0] sh;
        e  = {x[3], x[0], x[2], x[1]};
        sh = tbl >> {e, 1'b0};
        return sh[1:0];
    endfunction

    function automatic logic [7:0] fk(input logic [7:0] d, input logic [7:0] k,
                                      input logic [31:0] t0, input logic [31:0] t1);
        logic [7:0] t;
        logic [3:0] s;
        logic [3:0] p;
        t = {d[0], d[3], d[2], d[1], d[2], d[1], d[0], d[3]} ^ k;
        s = {sbox(t0, t[7:4]), sbox(t1, t[3:0])};
        p = {s[2], s[0], s[1], s[3]};
        return {d[7:4] ^ p, d[3:0]};
    endfunction

    // Round datapath: decrypt walks the subkey schedule backwards.
    always_comb begin
        round_idx_s = dec_r ? (LAST_ROUND - cnt_r) : cnt_r;
        subkey_s    = subkey(key_r, round_idx_s);
        fk_s        = fk(data_r, subkey_s, S0, S1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_n = ROUND;
                else          state_n = IDLE;
            end
            ROUND: begin
                if (cnt_r == LAST_ROUND) state_n = DONE;
                else                     state_n = ROUND;
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
                else           state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs; reset discards any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= 4'd0;
            data_r      <= 8'd0;
            key_r       <= 10'd0;
            dec_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
        end else begin
            in_ready_r  <= (state_n == IDLE);
            out_valid_r <= (state_n == DONE);
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        data_r <= ip_fwd(in_data);
                        key_r  <= in_key;
                        dec_r  <= in_decrypt;
                        cnt_r  <= 4'd0;
                    end
                end
                ROUND: begin
                    if (cnt_r == LAST_ROUND) begin
                        out_data_r <= ip_inv(fk_s);
                    end else begin
                        data_r <= {fk_s[3:0], fk_s[7:4]};
                        cnt_r  <= cnt_r + 4'd1;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_s_des_round_engine.sv
// Directed bench for s_des_round_engine: two instances (2 and 8 rounds) checked against a
// table-driven S-DES model through per-instance expected-result queues.
module tb_s_des_round_engine;

    localparam int NR_A = 2;
    localparam int NR_B = 8;
`ifdef S_DES_IP_EN
    localparam bit IP_EN = 1'b1;
`else
    localparam bit IP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s0_tbl = 32'hB7D81BB1;
    logic [31:0] s1_tbl = 32'hC613D2E4;

    logic        in_valid_s   [2];
    logic        in_ready_s   [2];
    logic [7:0]  in_data_s    [2];
    logic [9:0]  in_key_s     [2];
    logic        in_decrypt_s [2];
    logic        out_valid_s  [2];
    logic        out_ready_s  [2];
    logic [7:0]  out_data_s   [2];

    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    int          n_cmp = 0;
    int          n_err = 0;

    int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int P8_T [10] = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    int IP_T [10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    int IPI_T[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    int EP_T [10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    int P4_T [10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    s_des_round_engine #(.NUM_ROUNDS(NR_A), .KEY_SHIFT_FIRST(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_s[0]),
        .in_key(in_key_s[0]), .in_decrypt(in_decrypt_s[0]), .S0(s0_tbl), .S1(s1_tbl),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0])
    );

    s_des_round_engine #(.NUM_ROUNDS(NR_B), .KEY_SHIFT_FIRST(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_s[1]),
        .in_key(in_key_s[1]), .in_decrypt(in_decrypt_s[1]), .S0(s0_tbl), .S1(s1_tbl),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1])
    );

    // Generic 1-indexed MSB-first permutation: output bit j takes input bit tbl[j].
    function automatic logic [9:0] perm(input logic [9:0] x, input int nin, input int nout,
                                        input int tbl[10]);
        logic [9:0] y = '0;
        for (int j = 0; j < nout; j++) y[nout-1-j] = x[nin - tbl[j]];
        return y;
    endfunction

    function automatic logic [1:0] sbox_m(input logic [31:0] tbl, input logic [3:0] x);
        int e;
        e = int'({x[3], x[0]}) * 4 + int'({x[2], x[1]});
        return 2'((tbl >> (2 * e)) & 32'h3);
    endfunction

    function automatic logic [7:0] sdes_model(input logic [7:0] din, input logic [9:0] key,
                                              input logic dec, input int nr);
        logic [9:0] p, w;
        logic [4:0] l, r;
        logic [7:0] d, k, t;
        logic [3:0] s, pv;
        int ki, rot;
        w = perm({2'b00, din}, 8, 8, IP_T);
        d = IP_EN ? w[7:0] : din;
        p = perm(key, 10, 10, P10_T);
        for (int rd = 0; rd < nr; rd++) begin
            ki  = dec ? nr - 1 - rd : rd;
            rot = (1 + 2 * ki) % 5;
            l = p[9:5];
            r = p[4:0];
            for (int n = 0; n < rot; n++) begin
                l = {l[3:0], l[4]};
                r = {r[3:0], r[4]};
            end
            w  = perm({l, r}, 10, 8, P8_T);
            k  = w[7:0];
            w  = perm({6'b000000, d[3:0]}, 4, 8, EP_T);
            t  = w[7:0] ^ k;
            s  = {sbox_m(s0_tbl, t[7:4]), sbox_m(s1_tbl, t[3:0])};
            w  = perm({6'b000000, s}, 4, 4, P4_T);
            pv = w[3:0];
            d  = {d[7:4] ^ pv, d[3:0]};
            if (rd != nr - 1) d = {d[3:0], d[7:4]};
        end
        w = perm({2'b00, d}, 8, 8, IPI_T);
        return IP_EN ? w[7:0] : d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_exp(input int sel, input logic [7:0] d, input logic [9:0] k,
                            input logic dec, input logic [7:0] e);
        in_data_s[sel]    = d;
        in_key_s[sel]     = k;
        in_decrypt_s[sel] = dec;
        in_valid_s[sel]   = 1'b1;
        chk("in_ready_idle", 32'(in_ready_s[sel]), 32'd1);
        if (sel == 0) exp_a.push_back(e);
        else          exp_b.push_back(e);
        @(posedge clk); #1;
        in_valid_s[sel] = 1'b0;
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic [9:0] k, input logic dec);
        send_exp(sel, d, k, dec, sdes_model(d, k, dec, (sel == 0) ? NR_A : NR_B));
    endtask

    // Latency counted in clock edges including the accept edge.
    task automatic wait_done(input int sel, input int already);
        int n = 0;
        int nr;
        logic rdy_seen = 1'b0;
        nr = (sel == 0) ? NR_A : NR_B;
        while (!out_valid_s[sel] && n < 40) begin
            rdy_seen = rdy_seen | in_ready_s[sel];
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n + already + 1), 32'(nr + 1));
        chk("in_ready_busy", 32'(rdy_seen), 32'd0);
    endtask

    task automatic take(input int sel, output logic [7:0] res);
        logic [7:0] e = 8'h00;
        int depth;
        depth = (sel == 0) ? exp_a.size() : exp_b.size();
        chk("scoreboard_depth", 32'(depth), 32'd1);
        if (depth > 0) e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
        res = out_data_s[sel];
        chk("out_data", 32'(res), 32'(e));
        out_ready_s[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[sel] = 1'b0;
        chk("out_valid_drop", 32'(out_valid_s[sel]), 32'd0);
        chk("in_ready_back", 32'(in_ready_s[sel]), 32'd1);
    endtask

    initial begin
        logic [7:0] res, c, x, e;
        logic [9:0] k;
        logic       seen;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid_s[i] = 1'b0; in_data_s[i] = 8'h00; in_key_s[i] = 10'h000;
            in_decrypt_s[i] = 1'b0; out_ready_s[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", 32'(in_ready_s[i]), 32'd1);
            chk("rst_out_valid", 32'(out_valid_s[i]), 32'd0);
            chk("rst_out_data", 32'(out_data_s[i]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Reference vector and its inverse.
`ifdef S_DES_IP_EN
        send_exp(0, 8'b10010111, 10'b1010000010, 1'b0, 8'b00111000);
`else
        send(0, 8'b10010111, 10'b1010000010, 1'b0);
`endif
        wait_done(0, 0);
        take(0, res);
`ifdef S_DES_IP_EN
        send_exp(0, 8'b00111000, 10'b1010000010, 1'b1, 8'b10010111);
`else
        send(0, res, 10'b1010000010, 1'b1);
`endif
        wait_done(0, 0);
        take(0, c);
        chk("roundtrip_ref", 32'(c), 32'h97);

        // Back-pressure: hold in DONE for 10 cycles while in_valid is offered.
        send(0, 8'h5A, 10'h2F3, 1'b0);
        wait_done(0, 0);
        e = exp_a[0];
        in_data_s[0] = 8'hA5;
        in_valid_s[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid_s[0]), 32'd1);
            chk("hold_out_data", 32'(out_data_s[0]), 32'(e));
            chk("hold_in_ready", 32'(in_ready_s[0]), 32'd0);
        end
        in_valid_s[0] = 1'b0;
        take(0, res);

        // Reset during round 1: block is dropped, nothing emitted.
        send(0, 8'h3E, 10'h1C7, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid_s[0]), 32'd0);
        chk("midrst_in_ready", 32'(in_ready_s[0]), 32'd1);
        chk("midrst_out_data", 32'(out_data_s[0]), 32'd0);
        void'(exp_a.pop_front());
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid_s[0];
        end
        chk("midrst_no_output", 32'(seen), 32'd0);
        send(0, 8'hE1, 10'h33B, 1'b0);
        wait_done(0, 0);
        take(0, res);

        // New in_valid during ROUND is ignored.
        send(0, 8'hC3, 10'h0F5, 1'b0);
        in_data_s[0] = 8'h3C;
        in_key_s[0] = 10'h3FF;
        in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        chk("round_in_ready", 32'(in_ready_s[0]), 32'd0);
        in_valid_s[0] = 1'b0;
        wait_done(0, 1);
        take(0, res);

        // Random blocks on the 2-round engine, both directions.
        for (int i = 0; i < 4; i++) begin
            send(0, 8'($urandom), 10'($urandom), 1'($urandom));
            wait_done(0, 0);
            take(0, res);
        end

        // 8-round engine: encrypt then decrypt random blocks.
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom);
            k = 10'($urandom);
            send(1, x, k, 1'b0);
            wait_done(1, 0);
            take(1, c);
            send(1, c, k, 1'b1);
            wait_done(1, 0);
            take(1, res);
            chk("roundtrip_8", 32'(res), 32'(x));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
